debouncer_multi: RTL and testbench
==================================

# debouncer_multi

Parametrised multi-channel push-button/switch debouncer for the board-level input path: each of `NUM_CH` asynchronous inputs is two-flop synchronised, filtered until it has held a new level for `STABLE_CNT` consecutive cycles, and presented as a clean level. Each channel also provides one-cycle rise/fall strobes and a long-press strobe. It sits between the top-level pad inputs and the control FSMs, replacing per-button single-channel debouncers.

## Interface
- One clock; reset is asynchronous and active-low.
- `NUM_CH`, 4: number of independent channels.
- `CNT_W`, 27: width of the stability counter.
- `STABLE_CNT`, 6000000: consecutive mismatching cycles required to accept a new level. Constraint: 1 ≤ value ≤ 2^CNT_W−1.
- `HOLD_W`, 28: width of the long-press counter.
- `HOLD_CNT`, 100000000: cycles `pb_state` must stay 1 before `pb_hold` fires. Constraint: 1 ≤ value ≤ 2^HOLD_W−1.
- `INIT_LEVEL`, 0: reset value of every synchroniser flop and of `pb_state`, applied to all channels.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `pb_in` input NUM_CH: raw asynchronous button levels.
- `pb_state` output NUM_CH: debounced level. Reset value `{NUM_CH{INIT_LEVEL}}`.
- `pb_rise` output NUM_CH: one-cycle strobe on an accepted 0→1 transition. Reset value 0.
- `pb_fall` output NUM_CH: one-cycle strobe on an accepted 1→0 transition. Reset value 0.
- `pb_hold` output NUM_CH: one-cycle strobe once per press after `HOLD_CNT` cycles at 1. Reset value 0.

## Operation
- Channels are fully independent; there is no shared state apart from `clk`/`rst_n`.
- Synchroniser: `sync0 <= pb_in[i]`, `sync1 <= sync0`. Only `sync1` feeds the filter.
- Stability counter `cnt`, evaluated every cycle:
  - If `sync1 == pb_state`: `cnt <= 0`.
  - Else if `cnt == STABLE_CNT-1`: `pb_state <= ~pb_state` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- Any single matching cycle (a bounce) restarts the count from 0. The counter never wraps, because it clears at `STABLE_CNT-1`.
- Edge strobes are registered in the same cycle `pb_state` flips:
  - `pb_rise` = 1 for exactly one cycle when the flip is 0→1.
  - `pb_fall` = 1 for exactly one cycle when the flip is 1→0.
  - Otherwise both are 0.
- Long-press counter `hcnt`:
  - Cleared while `pb_state == 0`, and on the cycle of any flip.
  - While `pb_state == 1`, increments until it reaches `HOLD_CNT-1`.
  - At that point `pb_hold` pulses for one cycle and `hcnt` saturates at `HOLD_CNT`. There is no repeat until a fall and a new rise.
- Reset asserted mid-operation: all flops go asynchronously to their reset values and any strobe in flight is dropped.
- On reset release, no strobe fires, even when `pb_in != INIT_LEVEL`. The level is accepted through the normal filter and produces its strobe then.

## Timing
- `pb_in` is first sampled at new level at edge k.
- `sync1` holds the new value after edge k+1.
- The first mismatch count happens at edge k+2.
- `pb_state` flips and `pb_rise`/`pb_fall` assert after edge k+1+STABLE_CNT. Total latency is STABLE_CNT+2 edges counting edge k.
- `pb_hold` asserts HOLD_CNT cycles after the `pb_rise` edge, provided no flip occurs in between.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Sub-module `debounce_ch` implements one channel: synchroniser, stability counter, hold counter and strobes. The top generates `NUM_CH` instances.
- The default constants (`STABLE_CNT`, `HOLD_CNT`, `CNT_W`, `HOLD_W`) belong in the shared package `debounce_pkg`, so that clock-frequency changes are made in one place.
- Parameter range checks run at elaboration: a generate-time error for out-of-range values.

## Test plan
Bench parameters: NUM_CH=2, STABLE_CNT=4, HOLD_CNT=10, INIT_LEVEL=0.
- **Clean press:** ch0 0→1 at edge 0, held → `pb_state[0]`=1 and `pb_rise[0]` pulses after edge 5. `pb_fall` stays 0, and ch1 outputs are unchanged.
- **Bounce:** ch0 toggles 1,0,1,0 every 2 cycles, then stays 1 → no flip during bouncing. The flip occurs 4+2 edges after the last edge, with exactly one `pb_rise`.
- **Long press:** ch0 held at 1 for 30 cycles → `pb_hold[0]` pulses exactly once, 10 cycles after `pb_rise`. On release, `pb_fall` pulses once and `pb_hold` does not repeat.
- **Short press:** ch0 high for 3 cycles → no change in `pb_state`, and no strobes.
- **Reset mid-count:** ch1 mismatch with `cnt`=2, then `rst_n` pulsed low → outputs return to 0 asynchronously. After release, the full 4-cycle stability window restarts before any flip.
- **Simultaneous channels:** ch0 rises while ch1 falls on the same edge → both strobes fire in the same cycle, each independently correct.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults and types for the multi-channel debouncer.
// Retune the default counts here when the system clock frequency changes.
package debounce_pkg;

   localparam int unsigned DefaultCntW      = 27;
   localparam int unsigned DefaultStableCnt = 6000000;
   localparam int unsigned DefaultHoldW     = 28;
   localparam int unsigned DefaultHoldCnt   = 100000000;

   typedef struct packed {
      logic state;
      logic rise;
      logic fall;
      logic hold;
   } ch_out_t;

   // True when val is usable as a terminal count held in a w-bit counter.
   function automatic bit cnt_fits(longint unsigned val, int unsigned w);
      return (val >= 64'd1) && (val <= ((64'd1 << w) - 64'd1));
   endfunction

endpackage

// File: rtl/debouncer_multi_if.sv
// Button bus between the pad inputs and the debouncer.
// The master drives the raw levels; the slave returns filtered levels and strobes.
interface debouncer_multi_if #(
   parameter int unsigned NUM_CH = 4
);
   logic [NUM_CH-1:0] pb_in;
   logic [NUM_CH-1:0] pb_state;
   logic [NUM_CH-1:0] pb_rise;
   logic [NUM_CH-1:0] pb_fall;
   logic [NUM_CH-1:0] pb_hold;

   modport master (
      output pb_in,
      input  pb_state,
      input  pb_rise,
      input  pb_fall,
      input  pb_hold
   );

   modport slave (
      input  pb_in,
      output pb_state,
      output pb_rise,
      output pb_fall,
      output pb_hold
   );
endinterface

// File: rtl/debounce_ch.sv
// One debounced channel: two-flop synchroniser, stability filter,
// rise/fall strobes and a once-per-press long-hold strobe.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int unsigned CNT_W      = DefaultCntW,
   parameter int unsigned STABLE_CNT = DefaultStableCnt,
   parameter int unsigned HOLD_W     = DefaultHoldW,
   parameter int unsigned HOLD_CNT   = DefaultHoldCnt,
   parameter bit          INIT_LEVEL = 1'b0
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    pb_i,
   output ch_out_t out_o
);

   if (!cnt_fits(STABLE_CNT, CNT_W)) begin : g_bad_stable
      $error("debounce_ch: STABLE_CNT out of range for CNT_W");
   end
   if (!cnt_fits(HOLD_CNT, HOLD_W)) begin : g_bad_hold
      $error("debounce_ch: HOLD_CNT out of range for HOLD_W");
   end

   localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(STABLE_CNT - 1);
   localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_CNT - 1);
   localparam logic [HOLD_W-1:0] HoldSat  = HOLD_W'(HOLD_CNT);

   logic              sync0_q, sync1_q;
   logic              state_q, state_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              hold_q, hold_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hcnt_q, hcnt_d;
   logic              flip;

   always_comb begin
      flip  = 1'b0;
      cnt_d = cnt_q;
      if (sync1_q == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         flip  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      state_d = state_q ^ flip;
      rise_d  = flip & ~state_q;
      fall_d  = flip & state_q;

      // Saturating one past the terminal value blocks a repeat until the next press.
      hold_d = 1'b0;
      hcnt_d = hcnt_q;
      if (flip || !state_q) begin
         hcnt_d = '0;
      end else if (hcnt_q == HoldLast) begin
         hold_d = 1'b1;
         hcnt_d = HoldSat;
      end else if (hcnt_q != HoldSat) begin
         hcnt_d = hcnt_q + HOLD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_q <= INIT_LEVEL;
         sync1_q <= INIT_LEVEL;
         state_q <= INIT_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         hold_q  <= 1'b0;
         cnt_q   <= '0;
         hcnt_q  <= '0;
      end else begin
         sync0_q <= pb_i;
         sync1_q <= sync0_q;
         state_q <= state_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         hcnt_q  <= hcnt_d;
      end
   end

   assign out_o = '{state: state_q, rise: rise_q, fall: fall_q, hold: hold_q};

endmodule

// File: rtl/debouncer_multi.sv
// NUM_CH independent button debouncers sharing only clock and reset.
module debouncer_multi
   import debounce_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned CNT_W      = DefaultCntW,
   parameter int unsigned STABLE_CNT = DefaultStableCnt,
   parameter int unsigned HOLD_W     = DefaultHoldW,
   parameter int unsigned HOLD_CNT   = DefaultHoldCnt,
   parameter bit          INIT_LEVEL = 1'b0
) (
   input logic              clk,
   input logic              rst_n,
   debouncer_multi_if.slave pb_if
);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("debouncer_multi: NUM_CH must be at least 1");
   end

   logic [NUM_CH-1:0] state_w, rise_w, fall_w, hold_w;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_out_t ch_out;

      debounce_ch #(
         .CNT_W      (CNT_W),
         .STABLE_CNT (STABLE_CNT),
         .HOLD_W     (HOLD_W),
         .HOLD_CNT   (HOLD_CNT),
         .INIT_LEVEL (INIT_LEVEL)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .pb_i  (pb_if.pb_in[i]),
         .out_o (ch_out)
      );

      assign state_w[i] = ch_out.state;
      assign rise_w[i]  = ch_out.rise;
      assign fall_w[i]  = ch_out.fall;
      assign hold_w[i]  = ch_out.hold;
   end

   assign pb_if.pb_state = state_w;
   assign pb_if.pb_rise  = rise_w;
   assign pb_if.pb_fall  = fall_w;
   assign pb_if.pb_hold  = hold_w;

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: stimulus pushes expected output events
// (cycle + values) into a queue; a monitor pops and compares on every DUT event.
module tb_debouncer_multi;

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic [1:0] r;
      logic [1:0] f;
      logic [1:0] h;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic clk    = 1'b0;
   logic rst_n  = 1'b0;

   debouncer_multi_if #(.NUM_CH(2)) pb_if ();

   debouncer_multi #(
      .NUM_CH     (2),
      .CNT_W      (27),
      .STABLE_CNT (4),
      .HOLD_W     (28),
      .HOLD_CNT   (10),
      .INIT_LEVEL (1'b0)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pb_if (pb_if)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int off, input logic [1:0] st, input logic [1:0] r,
                       input logic [1:0] f, input logic [1:0] h);
      exp_t e;
      e.cyc = cyc + off;
      e.st  = st;
      e.r   = r;
      e.f   = f;
      e.h   = h;
      exp_q.push_back(e);
   endtask

   task automatic at_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Monitor: any strobe or level change is an output event.
   initial begin
      logic [1:0] prev;
      exp_t       e;
      prev = 2'b00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = pb_if.pb_state;
         end else if ((pb_if.pb_rise | pb_if.pb_fall | pb_if.pb_hold) != 2'b00 ||
                      pb_if.pb_state != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: cyc=%0d state=%b rise=%b fall=%b hold=%b, expected none",
                        cyc, pb_if.pb_state, pb_if.pb_rise, pb_if.pb_fall, pb_if.pb_hold);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || pb_if.pb_state !== e.st || pb_if.pb_rise !== e.r ||
                   pb_if.pb_fall !== e.f || pb_if.pb_hold !== e.h) begin
                  errors++;
                  $display("FAIL event: got cyc=%0d state=%b rise=%b fall=%b hold=%b, expected cyc=%0d state=%b rise=%b fall=%b hold=%b",
                           cyc, pb_if.pb_state, pb_if.pb_rise, pb_if.pb_fall, pb_if.pb_hold,
                           e.cyc, e.st, e.r, e.f, e.h);
               end
            end
            prev = pb_if.pb_state;
         end
      end
   end

   initial begin
      pb_if.pb_in = 2'b00;
      rst_n = 1'b0;
      at_neg(2);
      chk("reset_state", pb_if.pb_state, 2'b00);
      chk("reset_rise",  pb_if.pb_rise,  2'b00);
      chk("reset_fall",  pb_if.pb_fall,  2'b00);
      chk("reset_hold",  pb_if.pb_hold,  2'b00);
      rst_n = 1'b1;
      at_neg(3);

      // Clean press held 30 cycles, then release.
      pb_if.pb_in = 2'b01;
      push(6,  2'b01, 2'b01, 2'b00, 2'b00);
      push(16, 2'b01, 2'b00, 2'b00, 2'b01);
      at_neg(30);
      pb_if.pb_in = 2'b00;
      push(6, 2'b00, 2'b00, 2'b01, 2'b00);
      at_neg(20);

      // Bounce: 2-cycle pulses never reach the window; final level accepted.
      pb_if.pb_in = 2'b01; at_neg(2);
      pb_if.pb_in = 2'b00; at_neg(2);
      pb_if.pb_in = 2'b01; at_neg(2);
      pb_if.pb_in = 2'b00; at_neg(2);
      pb_if.pb_in = 2'b01;
      push(6,  2'b01, 2'b01, 2'b00, 2'b00);
      push(16, 2'b01, 2'b00, 2'b00, 2'b01);
      at_neg(20);
      pb_if.pb_in = 2'b00;
      push(6, 2'b00, 2'b00, 2'b01, 2'b00);
      at_neg(12);

      // Short press: 3 cycles reaches cnt=3 but never flips.
      pb_if.pb_in = 2'b01; at_neg(3);
      pb_if.pb_in = 2'b00; at_neg(12);

      // Reset mid-count on ch1 while ch0 is pressed.
      pb_if.pb_in = 2'b01;
      push(6, 2'b01, 2'b01, 2'b00, 2'b00);
      at_neg(8);
      pb_if.pb_in = 2'b11;
      at_neg(4);
      rst_n = 1'b0;
      #1;
      chk("async_reset_state", pb_if.pb_state, 2'b00);
      chk("async_reset_rise",  pb_if.pb_rise,  2'b00);
      chk("async_reset_fall",  pb_if.pb_fall,  2'b00);
      chk("async_reset_hold",  pb_if.pb_hold,  2'b00);
      at_neg(2);
      rst_n = 1'b1;
      push(6,  2'b11, 2'b11, 2'b00, 2'b00);
      push(16, 2'b11, 2'b00, 2'b00, 2'b11);
      at_neg(22);

      // ch0 released, then ch0 rises while ch1 falls on the same edge.
      pb_if.pb_in = 2'b10;
      push(6, 2'b10, 2'b00, 2'b01, 2'b00);
      at_neg(10);
      pb_if.pb_in = 2'b01;
      push(6,  2'b01, 2'b01, 2'b10, 2'b00);
      push(16, 2'b01, 2'b00, 2'b00, 2'b01);
      at_neg(20);
      pb_if.pb_in = 2'b00;
      push(6, 2'b00, 2'b00, 2'b01, 2'b00);
      at_neg(12);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: %0d still pending, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
